// File: rtl/gmsk_pkg.sv
// Shared GMSK definitions: burst FSM states, framing defaults and the
// modulator sample depth, used by the sequencer and the modulator.
package gmsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEAD_IN  = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_TAIL_OUT = 3'd3,
        ST_FLUSH    = 3'd4,
        ST_GUARD    = 3'd5
    } state_t;

    localparam int DEF_CLK_PER_SAMPLE     = 4;
    localparam int DEF_SAMPLES_PER_SYMBOL = 128;
    localparam int DEF_TAIL_BITS          = 3;
    localparam int DEF_FLUSH_SYMBOLS      = 3;
    localparam int DEF_GUARD_SYMBOLS      = 8;
    localparam int DEF_LEN_BITS           = 8;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gmsk_strobe_gen.sv
// Sample/symbol timing for the GMSK modulator; counters run while `run` is
// high and the strobes are emitted only while `strobe_en` is high.
module gmsk_strobe_gen
    import gmsk_pkg::*;
#(
    parameter int CLK_PER_SAMPLE     = DEF_CLK_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic strobe_en,
    output logic sample_strobe,
    output logic symbol_strobe,
    output logic end_of_symbol
);

    localparam int CW = cnt_width(CLK_PER_SAMPLE);
    localparam int SW = cnt_width(SAMPLES_PER_SYMBOL);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_PER_SAMPLE - 1);
    localparam logic [CW-1:0] CLK_SYM   = CW'(CLK_PER_SAMPLE - 2);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_SYMBOL - 1);

    logic [CW-1:0] clk_cnt;
    logic [SW-1:0] samp_cnt;
    logic          samp_tick;

    assign samp_tick = run && (clk_cnt == CLK_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt  <= '0;
            samp_cnt <= '0;
        end else if (!run) begin
            clk_cnt  <= '0;
            samp_cnt <= '0;
        end else if (samp_tick) begin
            clk_cnt  <= '0;
            samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    // The symbol strobe leads the first sample strobe of its symbol by one clock.
    assign sample_strobe = strobe_en && samp_tick;
    assign symbol_strobe = strobe_en && run && (clk_cnt == CLK_SYM) && (samp_cnt == '0);
    assign end_of_symbol = samp_tick && (samp_cnt == SAMP_LAST);

endmodule

// File: rtl/gmsk_burst_sequencer.sv
// GMSK burst sequencer: frames lead-in tails, payload, trailing tails, flush
// and guard. Define GMSK_DIFF_ENCODE_EN for GSM differential payload encoding.
module gmsk_burst_sequencer
    import gmsk_pkg::*;
#(
    parameter int CLK_PER_SAMPLE     = DEF_CLK_PER_SAMPLE,
    parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
    parameter int TAIL_BITS          = DEF_TAIL_BITS,
    parameter int FLUSH_SYMBOLS      = DEF_FLUSH_SYMBOLS,
    parameter int GUARD_SYMBOLS      = DEF_GUARD_SYMBOLS,
    parameter int LEN_BITS           = DEF_LEN_BITS
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                burst_start,
    input  logic [LEN_BITS-1:0] burst_len,
    input  logic                bit_valid,
    input  logic                bit_data,
    output logic                bit_ready,
    output logic                symbol_strobe,
    output logic                sample_strobe,
    output logic                mod_bit,
    output logic                tx_active,
    output logic                burst_done,
    output logic                underflow
);

    localparam int PH_MAX0 = (TAIL_BITS > FLUSH_SYMBOLS) ? TAIL_BITS : FLUSH_SYMBOLS;
    localparam int PH_MAX  = (PH_MAX0 > GUARD_SYMBOLS) ? PH_MAX0 : GUARD_SYMBOLS;
    localparam int PW      = cnt_width(PH_MAX + 1);

    state_t              state_q, state_nx;
    logic [PW-1:0]       ph_cnt, ph_load;
    logic [LEN_BITS-1:0] pay_cnt;
    logic run, eos, ph_last, pay_last, start_ok, pay_strobe, raw_bit, enc_bit;

    assign run       = (state_q != ST_IDLE);
    assign tx_active = run && (state_q != ST_GUARD);
    assign start_ok  = (state_q == ST_IDLE) && burst_start;
    assign ph_last   = (ph_cnt == PW'(1));
    assign pay_last  = (pay_cnt == LEN_BITS'(1));

    gmsk_strobe_gen #(
        .CLK_PER_SAMPLE    (CLK_PER_SAMPLE),
        .SAMPLES_PER_SYMBOL(SAMPLES_PER_SYMBOL)
    ) u_strobe_gen (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .strobe_en    (tx_active),
        .sample_strobe(sample_strobe),
        .symbol_strobe(symbol_strobe),
        .end_of_symbol(eos)
    );

    // Payload handshake: a bit is consumed in the cycle where bit_valid && bit_ready;
    // bit_ready is a combinational pulse that can only occur on a PAYLOAD symbol_strobe,
    // and bit_valid is looked at in no other cycle.
    assign pay_strobe = (state_q == ST_PAYLOAD) && symbol_strobe;
    assign bit_ready  = pay_strobe && bit_valid;
    assign raw_bit    = bit_valid && bit_data;

`ifdef GMSK_DIFF_ENCODE_EN
    logic prev_bit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            prev_bit <= 1'b0;
        else if (state_q == ST_LEAD_IN && state_nx == ST_PAYLOAD)
            prev_bit <= 1'b1;
        else if (pay_strobe)
            prev_bit <= raw_bit;
    end

    assign enc_bit = raw_bit ^ prev_bit;
`else
    assign enc_bit = raw_bit;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:     if (burst_start)      state_nx = ST_LEAD_IN;
            ST_LEAD_IN:  if (eos && ph_last)   state_nx = (pay_cnt == '0) ? ST_TAIL_OUT : ST_PAYLOAD;
            ST_PAYLOAD:  if (eos && pay_last)  state_nx = ST_TAIL_OUT;
            ST_TAIL_OUT: if (eos && ph_last)   state_nx = ST_FLUSH;
            ST_FLUSH:    if (eos && ph_last)   state_nx = ST_GUARD;
            ST_GUARD:    if (eos && ph_last)   state_nx = ST_IDLE;
            default:                           state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        ph_load = '0;
        case (state_nx)
            ST_TAIL_OUT: ph_load = PW'(TAIL_BITS);
            ST_FLUSH:    ph_load = PW'(FLUSH_SYMBOLS);
            ST_GUARD:    ph_load = PW'(GUARD_SYMBOLS);
            default:     ph_load = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ph_cnt     <= '0;
            pay_cnt    <= '0;
            mod_bit    <= 1'b0;
            underflow  <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= (state_q == ST_GUARD) && (state_nx == ST_IDLE);
            if (start_ok) begin
                ph_cnt    <= PW'(TAIL_BITS);
                pay_cnt   <= burst_len;
                underflow <= 1'b0;
            end else if (eos) begin
                if (state_nx != state_q)
                    ph_cnt <= ph_load;
                else if (state_q != ST_PAYLOAD)
                    ph_cnt <= ph_cnt - 1'b1;
                if (state_q == ST_PAYLOAD)
                    pay_cnt <= pay_cnt - 1'b1;
            end
            if (symbol_strobe)
                mod_bit <= (state_q == ST_PAYLOAD) ? enc_bit : 1'b0;
            // A starved payload symbol still goes out, as a zero.
            if (pay_strobe && !bit_valid)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Directed bench for gmsk_burst_sequencer (CLK_PER_SAMPLE=4, SAMPLES_PER_SYMBOL=8)
// with a per-symbol mod_bit scoreboard.
module tb_gmsk_burst_sequencer;

    localparam int CPS      = 4;
    localparam int SPS      = 8;
    localparam int SYM_CLKS = CPS * SPS;

`ifdef GMSK_DIFF_ENCODE_EN
    localparam logic [255:0] EXP_BASIC = 256'b0110;
    localparam logic [255:0] EXP_UF    = 256'b010;
    localparam logic [255:0] EXP_DIFF  = 256'b0100;
    localparam logic [255:0] EXP_LONG  = '0;
    localparam logic         EXP_ONE   = 1'b0;
`else
    localparam logic [255:0] EXP_BASIC = 256'b1101;
    localparam logic [255:0] EXP_UF    = 256'b001;
    localparam logic [255:0] EXP_DIFF  = 256'b0011;
    localparam logic [255:0] EXP_LONG  = '1;
    localparam logic         EXP_ONE   = 1'b1;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       burst_start;
    logic [7:0] burst_len;
    logic       bit_valid;
    logic       bit_data;
    logic       bit_ready, symbol_strobe, sample_strobe, mod_bit;
    logic       tx_active, burst_done, underflow;

    logic [0:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rdy_cnt = 0, samp_total = 0, done_cnt = 0, samp_since = 0;
    bit last_sym = 1'b0, have_prev = 1'b0;

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    gmsk_burst_sequencer #(
        .CLK_PER_SAMPLE    (CPS),
        .SAMPLES_PER_SYMBOL(SPS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .burst_start  (burst_start),
        .burst_len    (burst_len),
        .bit_valid    (bit_valid),
        .bit_data     (bit_data),
        .bit_ready    (bit_ready),
        .symbol_strobe(symbol_strobe),
        .sample_strobe(sample_strobe),
        .mod_bit      (mod_bit),
        .tx_active    (tx_active),
        .burst_done   (burst_done),
        .underflow    (underflow)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset_n) begin
            last_sym   = 1'b0;
            have_prev  = 1'b0;
            samp_since = 0;
        end else begin
            if (last_sym) begin
                check("samp_after_sym", sample_strobe, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_symbol: got mod_bit %0d, expected no symbol", mod_bit);
                end else begin
                    check("mod_bit", mod_bit, exp_q.pop_front());
                end
            end
            if (symbol_strobe) begin
                check("sym_samp_overlap", sample_strobe, 0);
                if (have_prev) check("samp_per_sym", samp_since, SPS);
                samp_since = 0;
                have_prev  = 1'b1;
            end
            if (sample_strobe) begin
                samp_since++;
                samp_total++;
            end
            if (bit_ready) begin
                rdy_cnt++;
                check("rdy_on_sym", symbol_strobe, 1);
            end
            if (burst_done) begin
                done_cnt++;
                have_prev = 1'b0;
            end
            last_sym = symbol_strobe;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_bit_ready"}, bit_ready, 0);
        check({tag, "_symbol_strobe"}, symbol_strobe, 0);
        check({tag, "_sample_strobe"}, sample_strobe, 0);
        check({tag, "_mod_bit"}, mod_bit, 0);
        check({tag, "_tx_active"}, tx_active, 0);
        check({tag, "_burst_done"}, burst_done, 0);
        check({tag, "_underflow"}, underflow, 0);
    endtask

    // driver: called just after a posedge; r counts clocks since burst_start
    task automatic run_burst(input int len, input logic [255:0] data, input logic [255:0] vld,
                             input logic [255:0] exp_pay, input int mid_start_r);
        int rdy0, samp0, done_r, exp_rdy, k_sym;
        rdy0    = rdy_cnt;
        samp0   = samp_total;
        done_r  = -1;
        exp_rdy = 0;
        for (int k = 0; k < 3; k++) exp_q.push_back(1'b0);
        for (int j = 0; j < len; j++) begin
            exp_q.push_back(exp_pay[j]);
            if (vld[j]) exp_rdy++;
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(1'b0);
        burst_len   = 8'(len);
        burst_start = 1'b1;
        for (int r = 1; r <= (17 + len) * SYM_CLKS + 8; r++) begin
            @(posedge clock);
            #1;
            burst_start = 1'b0;
            if (r == 1) check("uf_clear_on_start", underflow, 0);
            if (r == 2) check("no_early_sym", symbol_strobe, 0);
            if (r == 2) check("tx_active_on", tx_active, 1);
            if (r == CPS - 1) check("first_sym", symbol_strobe, 1);
            if ((r - 1) % SYM_CLKS == 0) begin
                k_sym = (r - 1) / SYM_CLKS - 3;
                if (k_sym >= 0 && k_sym < len) begin
                    bit_valid = vld[k_sym];
                    bit_data  = data[k_sym];
                end else begin
                    bit_valid = 1'b0;
                end
            end
            if (r == mid_start_r) begin
                burst_len   = 8'd5;
                burst_start = 1'b1;
            end
            if (burst_done) begin
                done_r = r;
                break;
            end
        end
        bit_valid = 1'b0;
        check("done_time", done_r, (17 + len) * SYM_CLKS + 1);
        check("bit_ready_cnt", rdy_cnt - rdy0, exp_rdy);
        check("sample_cnt", samp_total - samp0, (9 + len) * SPS);
        check("symbols_left", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clock);
        #1;
        check("idle_after_done", tx_active, 0);
    endtask

    initial begin
        int d0;
        reset_n     = 1'b0;
        burst_start = 1'b0;
        burst_len   = '0;
        bit_valid   = 1'b0;
        bit_data    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_burst(4, 256'b1101, 256'hF, EXP_BASIC, -1);
        check("uf_none", underflow, 0);

        run_burst(3, 256'b011, 256'b101, EXP_UF, -1);
        check("uf_sticky", underflow, 1);
        repeat (20) @(posedge clock);
        #1;
        check("uf_sticky_idle", underflow, 1);

        run_burst(0, '0, '0, '0, 50);
        run_burst(4, 256'b0011, 256'hF, EXP_DIFF, -1);
        run_burst(255, '1, '1, EXP_LONG, -1);

        // abort mid-payload with an asynchronous reset
        for (int k = 0; k < 3; k++) exp_q.push_back(1'b0);
        exp_q.push_back(EXP_ONE);
        exp_q.push_back(EXP_ONE);
        bit_valid   = 1'b1;
        bit_data    = 1'b1;
        burst_len   = 8'd4;
        burst_start = 1'b1;
        @(posedge clock);
        #1;
        burst_start = 1'b0;
        repeat (SYM_CLKS * 4 + 8) @(posedge clock);
        #3;
        check("abort_in_payload", tx_active, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        check("abort_symbols_left", exp_q.size(), 0);
        exp_q.delete();
        d0        = done_cnt;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (24 * SYM_CLKS) @(posedge clock);
        #1;
        check("no_abort_done", done_cnt - d0, 0);

        run_burst(4, 256'b1101, 256'hF, EXP_BASIC, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gmsk_burst_sequencer.md
Name: gmsk_burst_sequencer

Overview:
- Controller that drives the GMSK modulator: generates its `sample_strobe` and `symbol_strobe` timing and feeds `input_bit`.
- Takes payload bits from a valid/ready stream.
- Frames each burst as lead-in tail bits, payload, trailing tail bits, pipeline flush and guard period.
- Sits between the burst assembler (upstream) and the modulator (downstream); one burst in flight at a time.

Parameters:
- CLK_PER_SAMPLE, 4: clocks per `sample_strobe`; must be >=2.
- SAMPLES_PER_SYMBOL, 128: `sample_strobe`s per symbol; equals the modulator ROM depth.
- TAIL_BITS, 3: zero bits sent before and after the payload.
- FLUSH_SYMBOLS, 3: extra zero symbols that drain the modulator's 3-bit history and output registers.
- GUARD_SYMBOLS, 8: idle symbols after a burst, strobes stopped, before the next burst may start.
- LEN_BITS, 8: width of `burst_len`.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- burst_start  in  1  single-cycle request to begin a burst; honoured only in IDLE.
- burst_len  in  LEN_BITS  payload bit count, sampled with `burst_start`; 0 is legal (tails only).
- bit_valid  in  1  payload bit available.
- bit_data  in  1  payload bit.
- bit_ready  out  1  one-cycle pulse; bit consumed this cycle.
- symbol_strobe  out  1  to modulator.
- sample_strobe  out  1  to modulator.
- mod_bit  out  1  to modulator `input_bit`.
- tx_active  out  1  high from LEAD_IN through FLUSH.
- burst_done  out  1  one-cycle pulse on entry to IDLE from GUARD.
- underflow  out  1  sticky; cleared on accepted `burst_start`.

Behaviour:
- Reset values: every output 0. FSM=IDLE, all counters 0, `mod_bit`=0.
- States and transitions:
  - IDLE -> LEAD_IN on `burst_start`; latch `burst_len`.
  - LEAD_IN (TAIL_BITS symbols) -> PAYLOAD, or -> TAIL_OUT directly when len=0.
  - PAYLOAD (len symbols) -> TAIL_OUT.
  - TAIL_OUT (TAIL_BITS symbols) -> FLUSH.
  - FLUSH (FLUSH_SYMBOLS symbols) -> GUARD.
  - GUARD (GUARD_SYMBOLS symbols, counted with internal timing, strobes suppressed) -> IDLE.
- Timing counters:
  - `clk_cnt` counts 0..CLK_PER_SAMPLE-1; `samp_cnt` counts 0..SAMPLES_PER_SYMBOL-1.
  - Both run only outside IDLE and restart from 0 on entry to LEAD_IN.
- `sample_strobe` = (`clk_cnt`==CLK_PER_SAMPLE-1) in LEAD_IN..FLUSH.
- Symbol boundary:
  - `symbol_strobe` = (`clk_cnt`==CLK_PER_SAMPLE-2 && `samp_cnt`==0) in LEAD_IN..FLUSH.
  - Always exactly one clock before the first `sample_strobe` of a symbol; never coincident with `sample_strobe`.
  - First `symbol_strobe` occurs CLK_PER_SAMPLE-1 clocks after `burst_start`.
- Symbol accounting: a symbol ends on the `sample_strobe` with `samp_cnt`==SAMPLES_PER_SYMBOL-1; the state symbol counter decrements there.
- `mod_bit`:
  - Registered on the `symbol_strobe` cycle; valid and stable through the whole symbol.
  - Value is 0 in LEAD_IN, TAIL_OUT and FLUSH.
  - In PAYLOAD it is `bit_data` if `bit_valid`. `bit_ready` pulses that same cycle.
- Underflow: `bit_valid`=0 at a PAYLOAD `symbol_strobe` -> `mod_bit`=0, `underflow` set, no `bit_ready`, symbol still counted.
- `bit_ready` never asserts outside PAYLOAD `symbol_strobe` cycles.
- `burst_start` outside IDLE is ignored, with no side effect.
- `reset_n` low at any time forces reset values asynchronously; an in-progress burst is abandoned with no `burst_done`.
- Length arithmetic: payload counter is LEN_BITS wide and counts down; no wrap, len=2^LEN_BITS-1 is supported.

Optional Feature:
- Macro: GMSK_DIFF_ENCODE_EN.
- Defined: payload bits are GSM-differentially encoded: `mod_bit` = d XOR prev.
  - prev = 1 at start of PAYLOAD.
  - prev updates to each consumed raw bit; an underflow bit counts as raw 0.
  - Tails and flush stay literal 0.
- Undefined: payload bits pass through unchanged.

Decomposition:
- Shared package gmsk_pkg holds:
  - state enum localparams;
  - TAIL_BITS, FLUSH_SYMBOLS, GUARD_SYMBOLS defaults;
  - SAMPLES_PER_SYMBOL, also used by the modulator for ROM size.
- One sub-module, gmsk_strobe_gen, holds `clk_cnt`/`samp_cnt` and emits `sample_strobe`, `symbol_strobe` and end_of_symbol, gated by an enable input.
- The FSM and bit handling stay in the top module.

Test Plan:
- Basic burst, CLK_PER_SAMPLE=4, SAMPLES_PER_SYMBOL=8, len=4, stream 1,0,1,1 always valid:
  - `mod_bit` per symbol = 0,0,0,1,0,1,1,0,0,0,0,0,0 (13 symbols with strobes), then 8 guard symbols.
  - `burst_done` at clock 21*32+1 after start.
  - 4 `bit_ready` pulses; 13*8 `sample_strobe`s.
- Strobe alignment: every `symbol_strobe` is followed exactly 1 clock later by `sample_strobe`; 8 `sample_strobe`s between consecutive `symbol_strobe`s; never coincident.
- Underflow: len=3, `bit_valid` low at the second payload symbol -> that `mod_bit`=0, `underflow`=1 held until the next `burst_start`, burst length unchanged.
- len=0 -> 6 zero symbols + flush, zero `bit_ready`; a `burst_start` mid-burst is ignored (symbol count unchanged).
- Async reset: assert `reset_n`=0 mid-PAYLOAD between clock edges -> all outputs 0 immediately; after release, a new burst runs normally and no `burst_done` appears for the aborted one.
- GMSK_DIFF_ENCODE_EN defined, payload 1,1,0,0 -> `mod_bit` payload symbols 0,0,1,0.
